// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// flush-to-bubble and saturating stall/kill counters.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W   = 64,
   parameter int unsigned       CTRL_W   = 24,
   parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
   parameter int unsigned       SKID     = 0,
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  kill_cnt
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0]  kill_cnt_q,   kill_cnt_d;

   logic              in_xfer;
   logic              out_xfer;
   logic              stall_inc;
   logic [1:0]        kill_inc;
   logic [CNT_W:0]    kill_sum;

   // Upstream ready: combinational through out_ready without skid, registered with skid
   always_comb begin
      if (SKID != 0) begin
         in_ready = !skid_valid_q;
      end else begin
         in_ready = !main_valid_q | out_ready;
      end
      in_xfer  = in_valid & in_ready;
      out_xfer = main_valid_q & out_ready;
   end

   // Next-state for the main register and the skid entry; flush overrides all transfers
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;

      if (flush) begin
         main_valid_d = 1'b0;
         main_data_d  = '0;
         main_ctrl_d  = CTRL_NOP;
         skid_valid_d = 1'b0;
      end else if (SKID != 0) begin
         if (!main_valid_q || out_xfer) begin
            // Main slot frees up: oldest held entry (skid) advances first
            if (skid_valid_q) begin
               main_valid_d = 1'b1;
               main_data_d  = skid_data_q;
               main_ctrl_d  = skid_ctrl_q;
               if (in_xfer) begin
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else begin
                  skid_valid_d = 1'b0;
               end
            end else if (in_xfer) begin
               main_valid_d = 1'b1;
               main_data_d  = in_data;
               main_ctrl_d  = in_ctrl;
            end else begin
               main_valid_d = 1'b0;
               main_ctrl_d  = CTRL_NOP;
            end
         end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
         end
      end else begin
         if (in_xfer) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
         end else if (out_xfer) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = CTRL_NOP;
         end
      end
   end

   // Saturating performance counters; an entry leaving on out_ready during flush is not a kill
   always_comb begin
      stall_inc = main_valid_q & !out_ready & !flush;
      if (stall_inc && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end

      kill_inc = '0;
      if (flush) begin
         kill_inc = {1'b0, main_valid_q & !out_ready} + {1'b0, skid_valid_q};
      end
      kill_sum = {1'b0, kill_cnt_q} + (CNT_W+1)'(kill_inc);
      if (kill_sum[CNT_W]) begin
         kill_cnt_d = '1;
      end else begin
         kill_cnt_d = kill_sum[CNT_W-1:0];
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_ctrl_q  <= CTRL_NOP;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= CTRL_NOP;
         stall_cnt_q  <= '0;
         kill_cnt_q   <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         stall_cnt_q  <= stall_cnt_d;
         kill_cnt_q   <= kill_cnt_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;
   assign stall_cnt = stall_cnt_q;
   assign kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (no skid, skid, skid with 4-bit
// counters) share one stimulus stream and are each checked against a FIFO model.
module tb_pipe_stage_reg;

   localparam logic [7:0] NOP = 8'hA5;
   localparam int SK   [3] = '{0, 1, 1};
   localparam int CMAX [3] = '{65535, 65535, 15};

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid, flush, out_ready;
   logic [15:0] in_data;
   logic [7:0]  in_ctrl;

   logic        irdy [3];
   logic        ov   [3];
   logic [15:0] od   [3];
   logic [7:0]  oc   [3];
   logic [15:0] sc   [3];
   logic [15:0] kc   [3];
   logic [3:0]  sc2_4, kc2_4;

   assign sc[2] = {12'h000, sc2_4};
   assign kc[2] = {12'h000, kc2_4};

   // Model: occupancy, held entries oldest-first, last seen data, counters
   int          mn  [3];
   logic [15:0] md  [3][2];
   logic [7:0]  mc  [3][2];
   logic [15:0] mld [3];
   bit          mdk [3];
   int          mst [3];
   int          mkl [3];

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .CTRL_NOP(NOP), .SKID(0), .CNT_W(16)) u_dut0 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(irdy[0]), .in_data(in_data),
      .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .out_ctrl(oc[0]), .stall_cnt(sc[0]), .kill_cnt(kc[0]));

   pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .CTRL_NOP(NOP), .SKID(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(irdy[1]), .in_data(in_data),
      .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .out_ctrl(oc[1]), .stall_cnt(sc[1]), .kill_cnt(kc[1]));

   pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .CTRL_NOP(NOP), .SKID(1), .CNT_W(4)) u_dut2 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(irdy[2]), .in_data(in_data),
      .in_ctrl(in_ctrl), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
      .out_data(od[2]), .out_ctrl(oc[2]), .stall_cnt(sc2_4), .kill_cnt(kc2_4));

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, i, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         mn[i] = 0; mld[i] = '0; mdk[i] = 1'b1; mst[i] = 0; mkl[i] = 0;
      end
   endtask

   task automatic check_outputs();
      for (int i = 0; i < 3; i++) begin
         chk("out_valid", i, 32'(ov[i]), 32'(mn[i] > 0));
         chk("out_ctrl", i, 32'(oc[i]), 32'((mn[i] > 0) ? mc[i][0] : NOP));
         if (mdk[i]) chk("out_data", i, 32'(od[i]), 32'(mld[i]));
         chk("stall_cnt", i, 32'(sc[i]), 32'(mst[i]));
         chk("kill_cnt", i, 32'(kc[i]), 32'(mkl[i]));
      end
   endtask

   // One clock of stimulus; entered and left 1ns after a rising edge
   task automatic step(input bit iv, input logic [15:0] d, input logic [7:0] c, input bit fl, input bit ordy);
      bit ir [3];
      bit ix, ox;
      in_valid = iv; in_data = d; in_ctrl = c; flush = fl; out_ready = ordy;
      #1;
      for (int i = 0; i < 3; i++) begin
         ir[i] = (SK[i] != 0) ? (mn[i] < 2) : (mn[i] == 0 || ordy);
         chk("in_ready", i, 32'(irdy[i]), 32'(ir[i]));
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         ox = (mn[i] > 0) && ordy;
         ix = iv && ir[i];
         if (fl) begin
            mkl[i] = mkl[i] + int'((mn[i] > 0) && !ordy) + int'(mn[i] == 2);
            if (mkl[i] > CMAX[i]) mkl[i] = CMAX[i];
            mn[i] = 0; mld[i] = '0; mdk[i] = 1'b1;
         end else begin
            if ((mn[i] > 0) && !ordy && (mst[i] < CMAX[i])) mst[i]++;
            if (ox) begin
               md[i][0] = md[i][1]; mc[i][0] = mc[i][1]; mn[i]--;
               if (mn[i] == 0 && SK[i] != 0) mdk[i] = 1'b0;
            end
            if (ix) begin
               md[i][mn[i]] = d; mc[i][mn[i]] = c; mn[i]++; mdk[i] = 1'b1;
            end
            if (mn[i] > 0) mld[i] = md[i][0];
         end
      end
      check_outputs();
   endtask

   // Asynchronous reset asserted between edges, checked before any clock edge
   task automatic do_reset();
      #2;
      rstn = 1'b0;
      #1;
      model_clear();
      check_outputs();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0; in_ctrl = '0;
      @(posedge clk);
      @(posedge clk);
      #3 rstn = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk("in_ready_post_rst", i, 32'(irdy[i]), 32'd1);
      check_outputs();
   endtask

   initial begin
      rstn = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0; in_ctrl = '0;
      model_clear();
      @(posedge clk); #1;
      do_reset();

      // Streaming with out_ready held high, data 1..4
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, 16'(k), 8'(k + 16), 1'b0, 1'b1);
         chk("stream_data", 0, 32'(od[0]), 32'(k));
      end
      step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);

      // Back-pressure fills the skid entry, then drains in order
      do_reset();
      step(1'b1, 16'h0011, 8'h11, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 16'h0022, 8'h22, 1'b0, 1'b0);
      chk("stall3", 1, 32'(sc[1]), 32'd3);
      chk("skid_full_ready", 1, 32'(irdy[1]), 32'd0);
      for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);

      // Flush with both entries held and stalled
      do_reset();
      step(1'b1, 16'h00A1, 8'h31, 1'b0, 1'b0);
      step(1'b1, 16'h00A2, 8'h32, 1'b0, 1'b0);
      step(1'b1, 16'h00A3, 8'h33, 1'b1, 1'b0);
      chk("flush_kill2", 1, 32'(kc[1]), 32'd2);
      chk("flush_valid", 1, 32'(ov[1]), 32'd0);
      chk("flush_ctrl", 1, 32'(oc[1]), 32'(NOP));
      chk("flush_data", 1, 32'(od[1]), 32'd0);
      step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);

      // Flush while the held entry leaves downstream
      do_reset();
      step(1'b1, 16'h00B1, 8'h41, 1'b0, 1'b1);
      step(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
      chk("flush_deliver_kill", 0, 32'(kc[0]), 32'd0);
      chk("flush_deliver_kill", 1, 32'(kc[1]), 32'd0);

      // Reset asserted mid-stall
      do_reset();
      step(1'b1, 16'h00C1, 8'h51, 1'b0, 1'b0);
      step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      do_reset();

      // Long stall saturates the narrow counter
      step(1'b1, 16'h00D1, 8'h61, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      chk("stall_sat", 2, 32'(sc[2]), 32'd15);
      chk("stall_20", 1, 32'(sc[1]), 32'd20);

      // Randomized traffic against the model
      do_reset();
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
              ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
